sysbus_arbiter: RTL

//  Shares the single Sysbus port between two masters: instruction fetch (M0) and data access (M1).

---
 rtl/sysbus_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 21 ++
 rtl/sysbus_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sysbus_pkg.sv
// Purpose : shared Sysbus types and tag-field constants for the bus arbiter slice.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state enum, tag bit positions, read/write and target encodings
// matching the SYSBUS_READ / SYSBUS_WRITE / SYSBUS_MEMORY bus macros.
package sysbus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      WDATA = 2'd2,
      RDATA = 2'd3
   } state_t;

   // Tag layout: [12] read/write, [11:8] target, [7:0] free for the master.
   localparam int TAG_RW_BIT     = 12;
   localparam int TAG_TARGET_MSB = 11;
   localparam int TAG_TARGET_LSB = 8;

   localparam logic       SYSBUS_READ   = 1'b1;
   localparam logic       SYSBUS_WRITE  = 1'b0;
   localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

endpackage

// File: rtl/rr_arb2.sv
// Purpose : 2-way round-robin picker; on a tie the requester that did not win last time wins.
// Latency : combinational, 0 cycles.
// Backpressure: none; the caller decides when a grant is taken.
//
// Ports: req[1:0] request vector, last = index granted previously, grant[1:0] one-hot (or 0).
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (req == 2'b11) begin
         grant = last ? 2'b01 : 2'b10;
      end else begin
         grant = req;
      end
   end

endmodule

// File: rtl/sysbus_arbiter.sv
// Purpose : shares one Sysbus port between fetch (M0) and data (M1), one whole transaction at a time.
// Latency : grant registered 1 cycle after request; data beats pass through combinationally.
// Backpressure: bus_reqack is forwarded to the owning master only; response acks come from the owner.
//
// Ports: clk, reset (sync, active-high); m0_*/m1_* master request/response channels;
// bus_* Sysbus request/response channels.
// Optional macro SYSBUS_ARB_STATS_EN adds grant_cnt0/grant_cnt1/conflict_cnt counters.
module sysbus_arbiter
   import sysbus_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int BEATS          = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      m0_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] m0_req,
   input  logic [BUS_TAG_WIDTH-1:0]  m0_reqtag,
   output logic                      m0_reqack,
   output logic                      m0_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] m0_resp,
   input  logic                      m0_respack,
   input  logic                      m1_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] m1_req,
   input  logic [BUS_TAG_WIDTH-1:0]  m1_reqtag,
   output logic                      m1_reqack,
   output logic                      m1_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] m1_resp,
   input  logic                      m1_respack,
   output logic                      bus_reqcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_req,
   output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   input  logic                      bus_reqack,
   input  logic                      bus_respcyc,
   input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   output logic                      bus_respack
`ifdef SYSBUS_ARB_STATS_EN
   ,
   output logic [31:0]               grant_cnt0,
   output logic [31:0]               grant_cnt1,
   output logic [31:0]               conflict_cnt
`endif
);

   localparam int CW = $clog2(BEATS) + 1;

   state_t                    state;
   logic                      owner;
   logic                      is_read;
   logic                      last_grant;
   logic [CW-1:0]             beat_cnt;
   logic [BUS_DATA_WIDTH-1:0] addr_q;
   logic [BUS_TAG_WIDTH-1:0]  tag_q;

   logic [1:0]                req_vec;
   logic [1:0]                grant;
   logic                      owner_reqcyc;
   logic [BUS_DATA_WIDTH-1:0] owner_req;
   logic                      owner_respack;
   logic                      last_beat;
   logic                      rd_hs;
   logic                      req_phase;

   // Routing follows ownership, so the response tag is not needed here.
   logic                      unused_resptag;
   assign unused_resptag = ^bus_resptag;

   assign req_vec = {m1_reqcyc, m0_reqcyc};

   rr_arb2 u_rr_arb2 (
      .req   (req_vec),
      .last  (last_grant),
      .grant (grant)
   );

   assign owner_reqcyc  = owner ? m1_reqcyc  : m0_reqcyc;
   assign owner_req     = owner ? m1_req     : m0_req;
   assign owner_respack = owner ? m1_respack : m0_respack;

   assign last_beat = (beat_cnt == CW'(BEATS - 1));
   assign rd_hs     = (state == RDATA) && bus_respcyc && owner_respack;
   assign req_phase = (state == ADDR) || (state == WDATA);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= 1'b0;
         is_read    <= 1'b0;
         last_grant <= 1'b1;
         beat_cnt   <= '0;
         addr_q     <= '0;
         tag_q      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|grant) begin
                  state      <= ADDR;
                  owner      <= grant[1];
                  last_grant <= grant[1];
                  is_read    <= ((grant[1] ? m1_reqtag[TAG_RW_BIT] : m0_reqtag[TAG_RW_BIT])
                                 == SYSBUS_READ);
                  addr_q     <= grant[1] ? m1_req    : m0_req;
                  tag_q      <= grant[1] ? m1_reqtag : m0_reqtag;
                  beat_cnt   <= '0;
               end
            end
            ADDR: begin
               if (bus_reqack) begin
                  state <= is_read ? RDATA : WDATA;
               end
            end
            WDATA: begin
               if (bus_reqack) begin
                  beat_cnt <= beat_cnt + CW'(1);
                  if (last_beat) begin
                     state <= IDLE;
                  end
               end
            end
            RDATA: begin
               if (rd_hs) begin
                  beat_cnt <= beat_cnt + CW'(1);
                  if (last_beat) begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Address phase comes from the registered grant; write beats stream straight from the owner.
   always_comb begin
      bus_reqcyc = 1'b0;
      bus_req    = '0;
      bus_reqtag = '0;
      case (state)
         ADDR: begin
            bus_reqcyc = 1'b1;
            bus_req    = addr_q;
            bus_reqtag = tag_q;
         end
         WDATA: begin
            bus_reqcyc = owner_reqcyc;
            bus_req    = owner_req;
            bus_reqtag = tag_q;
         end
         default: ;
      endcase
   end

   assign m0_reqack   = req_phase && !owner && bus_reqack;
   assign m1_reqack   = req_phase &&  owner && bus_reqack;
   assign m0_respcyc  = (state == RDATA) && !owner && bus_respcyc;
   assign m1_respcyc  = (state == RDATA) &&  owner && bus_respcyc;
   assign bus_respack = (state == RDATA) && owner_respack;
   assign m0_resp     = bus_resp;
   assign m1_resp     = bus_resp;

`ifdef SYSBUS_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_cnt0   <= '0;
         grant_cnt1   <= '0;
         conflict_cnt <= '0;
      end else if (state == IDLE) begin
         if (&req_vec)  conflict_cnt <= conflict_cnt + 32'd1;
         if (grant[0])  grant_cnt0   <= grant_cnt0 + 32'd1;
         if (grant[1])  grant_cnt1   <= grant_cnt1 + 32'd1;
      end
   end
`endif

   // The owner must keep its address request up until the bus accepts it.
   a_addr_hold: assert property (@(posedge clk) disable iff (reset)
                                 (state == ADDR) |-> owner_reqcyc);

endmodule
